// File: rtl/branch_predictor_pkg.sv
// Shared counter encodings for the branch predictor.
// Imported by the table and the saturating-counter update logic.
package branch_predictor_pkg;

   localparam logic [1:0] BP_SNT = 2'b00;
   localparam logic [1:0] BP_WNT = 2'b01;
   localparam logic [1:0] BP_WT  = 2'b10;
   localparam logic [1:0] BP_ST  = 2'b11;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Two-bit saturating counter next-state logic.
// Moves one step toward taken or not-taken, holding at either end.
module sat_counter2
   import branch_predictor_pkg::*;
(
   input  logic [1:0] ctr_i,
   input  logic       taken_i,
   output logic [1:0] ctr_o
);

   always_comb begin
      ctr_o = ctr_i;
      unique case (1'b1)
         taken_i && (ctr_i != BP_ST):   ctr_o = ctr_i + 2'd1;
         !taken_i && (ctr_i != BP_SNT): ctr_o = ctr_i - 2'd1;
         default:                       ctr_o = ctr_i;
      endcase
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped tagged 2-bit predictor with zero-latency guess,
// execute-stage training and wrapping branch/mispredict statistics.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int PC_WIDTH   = 32,
   parameter int LINES      = 8,
   parameter int STAT_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [PC_WIDTH-1:0]   pc_guess,
   input  logic                  is_br_guess,
   output logic                  br_pred,
   input  logic [PC_WIDTH-1:0]   pc_check,
   input  logic                  is_br_check,
   input  logic                  br_taken_check,
   input  logic                  br_pred_check,
   output logic                  br_pred_correct,
   input  logic                  stats_clr,
   output logic [STAT_WIDTH-1:0] br_count,
   output logic [STAT_WIDTH-1:0] mispred_count
);

   localparam int IDX_BITS = $clog2(LINES);
   localparam int TAG_W    = PC_WIDTH - 2 - IDX_BITS;

   logic [LINES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0] tag_q [LINES];
   logic [TAG_W-1:0] tag_d [LINES];
   logic [1:0]       ctr_q [LINES];
   logic [1:0]       ctr_d [LINES];

   logic [STAT_WIDTH-1:0] br_count_q, br_count_d;
   logic [STAT_WIDTH-1:0] mispred_count_q, mispred_count_d;

   logic [IDX_BITS-1:0] idx_g, idx_c;
   logic [TAG_W-1:0]    tag_g, tag_c;
   logic                hit_g, hit_c;
   logic                mispred;
   logic [1:0]          ctr_upd;
   logic                unused_pc_bits;

   assign idx_g = pc_guess[2 +: IDX_BITS];
   assign tag_g = pc_guess[PC_WIDTH-1 : 2+IDX_BITS];
   assign idx_c = pc_check[2 +: IDX_BITS];
   assign tag_c = pc_check[PC_WIDTH-1 : 2+IDX_BITS];
   assign unused_pc_bits = ^{pc_guess[1:0], pc_check[1:0]};

   // Guess reads registered state only, so a same-cycle train is not bypassed.
   assign hit_g   = valid_q[idx_g] && (tag_q[idx_g] == tag_g);
   assign br_pred = is_br_guess & hit_g & ctr_q[idx_g][1];

   assign hit_c           = valid_q[idx_c] && (tag_q[idx_c] == tag_c);
   assign mispred         = br_pred_check ^ br_taken_check;
   assign br_pred_correct = ~is_br_check | ~mispred;

   sat_counter2 u_sat (
      .ctr_i   (ctr_q[idx_c]),
      .taken_i (br_taken_check),
      .ctr_o   (ctr_upd)
   );

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      ctr_d   = ctr_q;
      if (is_br_check) begin
         if (hit_c) begin
            ctr_d[idx_c] = ctr_upd;
         end else begin
            valid_d[idx_c] = 1'b1;
            tag_d[idx_c]   = tag_c;
            ctr_d[idx_c]   = br_taken_check ? BP_WT : BP_WNT;
         end
      end
   end

   always_comb begin
      br_count_d      = br_count_q;
      mispred_count_d = mispred_count_q;
      if (stats_clr) begin
         br_count_d      = '0;
         mispred_count_d = '0;
      end else if (is_br_check) begin
         br_count_d = br_count_q + STAT_WIDTH'(1);
         if (mispred) mispred_count_d = mispred_count_q + STAT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q         <= '0;
         br_count_q      <= '0;
         mispred_count_q <= '0;
         for (int i = 0; i < LINES; i++) begin
            tag_q[i] <= '0;
            ctr_q[i] <= BP_WNT;
         end
      end else begin
         valid_q         <= valid_d;
         tag_q           <= tag_d;
         ctr_q           <= ctr_d;
         br_count_q      <= br_count_d;
         mispred_count_q <= mispred_count_d;
      end
   end

   assign br_count      = br_count_q;
   assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor (LINES=8, 4-bit stats so wrap is reachable).
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_guess;
   logic        is_br_guess;
   logic        br_pred;
   logic [31:0] pc_check;
   logic        is_br_check;
   logic        br_taken_check;
   logic        br_pred_check;
   logic        br_pred_correct;
   logic        stats_clr;
   logic [3:0]  br_count;
   logic [3:0]  mispred_count;

   logic [31:0] exp_q [$];
   logic [31:0] e;
   int pass_cnt  = 0;
   int total_cnt = 0;

   branch_predictor #(
      .PC_WIDTH   (32),
      .LINES      (8),
      .STAT_WIDTH (4)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .pc_guess        (pc_guess),
      .is_br_guess     (is_br_guess),
      .br_pred         (br_pred),
      .pc_check        (pc_check),
      .is_br_check     (is_br_check),
      .br_taken_check  (br_taken_check),
      .br_pred_check   (br_pred_check),
      .br_pred_correct (br_pred_correct),
      .stats_clr       (stats_clr),
      .br_count        (br_count),
      .mispred_count   (mispred_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic guess(input logic [31:0] pc, input logic isbr);
      pc_guess    = pc;
      is_br_guess = isbr;
      #1;
   endtask

   task automatic train(input logic [31:0] pc, input logic taken, input logic pred);
      @(negedge clk);
      pc_check       = pc;
      br_taken_check = taken;
      br_pred_check  = pred;
      is_br_check    = 1'b1;
      @(negedge clk);
      is_br_check = 1'b0;
   endtask

   task automatic cmp_pred(input string name);
      e = exp_q.pop_front();
      total_cnt++;
      if (br_pred !== e[0])
         $display("FAIL %s br_pred got %0b want %0b", name, br_pred, e[0]);
      else pass_cnt++;
   endtask

   task automatic cmp_counts(input string name);
      e = exp_q.pop_front();
      total_cnt++;
      if (br_count !== e[3:0])
         $display("FAIL %s br_count got %0d want %0d", name, br_count, e[3:0]);
      else pass_cnt++;
      e = exp_q.pop_front();
      total_cnt++;
      if (mispred_count !== e[3:0])
         $display("FAIL %s mispred_count got %0d want %0d", name, mispred_count, e[3:0]);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst            = 1'b0;
      stats_clr      = 1'b0;
      pc_check       = 32'h100;
      is_br_check    = 1'b1;
      br_taken_check = 1'b0;
      br_pred_check  = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      exp_q.push_back(32'd0);
      guess(32'h100, 1'b1);
      cmp_pred("reset_guess");
      total_cnt++;
      if (br_pred_correct !== 1'b0)
         $display("FAIL reset_correct got %0b want 0", br_pred_correct);
      else pass_cnt++;
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      cmp_counts("reset_counts");
      is_br_check = 1'b0;
      #1;
      total_cnt++;
      if (br_pred_correct !== 1'b1)
         $display("FAIL reset_nobr_correct got %0b want 1", br_pred_correct);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_first_train();
      @(negedge clk);
      pc_check       = 32'h100;
      br_taken_check = 1'b1;
      br_pred_check  = 1'b0;
      is_br_check    = 1'b1;
      #1;
      total_cnt++;
      if (br_pred_correct !== 1'b0)
         $display("FAIL first_correct got %0b want 0", br_pred_correct);
      else pass_cnt++;
      @(negedge clk);
      is_br_check = 1'b0;
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd1);
      cmp_counts("first_counts");
      exp_q.push_back(32'd1);
      guess(32'h100, 1'b1);
      cmp_pred("first_guess");
   endtask

   task automatic test_saturate();
      repeat (3) train(32'h100, 1'b1, 1'b1);
      exp_q.push_back(32'd1);
      guess(32'h100, 1'b1);
      cmp_pred("sat_strong");
      exp_q.push_back(32'd0);
      guess(32'h100, 1'b0);
      cmp_pred("sat_not_branch");
      train(32'h100, 1'b0, 1'b1);
      exp_q.push_back(32'd1);
      guess(32'h100, 1'b1);
      cmp_pred("sat_nt_once");
      train(32'h100, 1'b0, 1'b1);
      exp_q.push_back(32'd0);
      guess(32'h100, 1'b1);
      cmp_pred("sat_nt_twice");
      exp_q.push_back(32'd6);
      exp_q.push_back(32'd3);
      cmp_counts("sat_counts");
   endtask

   task automatic test_alias();
      train(32'h100, 1'b1, 1'b0);
      exp_q.push_back(32'd1);
      guess(32'h100, 1'b1);
      cmp_pred("alias_pre");
      train(32'h120, 1'b1, 1'b0);
      exp_q.push_back(32'd0);
      guess(32'h100, 1'b1);
      cmp_pred("alias_evicted");
      exp_q.push_back(32'd1);
      guess(32'h123, 1'b1);
      cmp_pred("alias_new_lowbits");
      exp_q.push_back(32'd0);
      guess(32'h104, 1'b1);
      cmp_pred("alias_other_idx");
      exp_q.push_back(32'd8);
      exp_q.push_back(32'd5);
      cmp_counts("alias_counts");
   endtask

   task automatic test_same_cycle();
      @(negedge clk);
      pc_check       = 32'h120;
      br_taken_check = 1'b0;
      br_pred_check  = 1'b1;
      is_br_check    = 1'b1;
      exp_q.push_back(32'd1);
      guess(32'h120, 1'b1);
      cmp_pred("same_old_hit");
      @(negedge clk);
      is_br_check = 1'b0;
      exp_q.push_back(32'd0);
      guess(32'h120, 1'b1);
      cmp_pred("same_new_hit");
      @(negedge clk);
      pc_check       = 32'h200;
      br_taken_check = 1'b1;
      br_pred_check  = 1'b0;
      is_br_check    = 1'b1;
      exp_q.push_back(32'd0);
      guess(32'h200, 1'b1);
      cmp_pred("same_old_miss");
      @(negedge clk);
      is_br_check = 1'b0;
      exp_q.push_back(32'd1);
      guess(32'h200, 1'b1);
      cmp_pred("same_new_alloc");
      exp_q.push_back(32'd10);
      exp_q.push_back(32'd7);
      cmp_counts("same_counts");
   endtask

   task automatic test_stats();
      @(negedge clk);
      pc_check       = 32'h300;
      br_taken_check = 1'b1;
      br_pred_check  = 1'b0;
      is_br_check    = 1'b1;
      stats_clr      = 1'b1;
      @(negedge clk);
      is_br_check = 1'b0;
      stats_clr   = 1'b0;
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      cmp_counts("clr_override");
      repeat (15) train(32'h300, 1'b0, 1'b1);
      exp_q.push_back(32'd15);
      exp_q.push_back(32'd15);
      cmp_counts("stats_max");
      train(32'h300, 1'b1, 1'b1);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd15);
      cmp_counts("br_wrap");
      train(32'h300, 1'b0, 1'b1);
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd0);
      cmp_counts("mis_wrap");
   endtask

   task automatic test_async_reset();
      train(32'h400, 1'b1, 1'b0);
      exp_q.push_back(32'd1);
      guess(32'h400, 1'b1);
      cmp_pred("ar_pre");
      #2;
      rst = 1'b0;
      #1;
      exp_q.push_back(32'd0);
      guess(32'h400, 1'b1);
      cmp_pred("ar_async_pred");
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      cmp_counts("ar_async_counts");
      is_br_check = 1'b1;
      @(negedge clk);
      is_br_check = 1'b0;
      rst         = 1'b1;
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      cmp_counts("ar_held");
      exp_q.push_back(32'd0);
      guess(32'h400, 1'b1);
      cmp_pred("ar_valid_cleared");
      train(32'h400, 1'b0, 1'b0);
      exp_q.push_back(32'd0);
      guess(32'h400, 1'b1);
      cmp_pred("ar_realloc_wnt");
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd0);
      cmp_counts("ar_resume");
   endtask

   initial begin
      pc_guess       = '0;
      is_br_guess    = 1'b0;
      pc_check       = '0;
      is_br_check    = 1'b0;
      br_taken_check = 1'b0;
      br_pred_check  = 1'b0;
      stats_clr      = 1'b0;
      rst            = 1'b0;
      test_reset();
      test_first_train();
      test_saturate();
      test_alias();
      test_same_cycle();
      test_stats();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
